sensor_conditioner: RTL
=======================

# sensor_conditioner

Input conditioning stage between the playfield sensor pins and the game FSM. It synchronizes, debounces and edge-detects the six sensor channels: target switch, four tunnel photo-sensors and the lose-arch sensor. It drives clean levels with the same polarity as the raw pins, so the FSM consumes them unchanged. It also produces one-cycle press/release pulses and per-channel stuck-sensor flags, which the MCU alert path uses.

## Interface
- `N_CH`, 6: number of sensor channels. Bit 0 = target, bits 1–4 = tunnel_p[0..3], bit 5 = lose_arch.
- `IDLE_LEVEL`, 6'b111110: inactive level per channel. Target is active-high; tunnel and lose-arch are active-low.
- `DEBOUNCE`, 2: consecutive differing samples required before a clean level changes. Legal range 1..255.
- `STUCK_CYCLES`, 1100: consecutive active cycles before a channel is flagged stuck (≈6 s at the ~183 Hz game clock). Legal range 2..65535.
- `clk`  in  1  game clock (divided oscillator tick).
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `raw_in`  in  N_CH  asynchronous sensor pins.
- `clean`  out  N_CH  debounced level, same polarity as `raw_in`.
- `press`  out  N_CH  one-cycle pulse when `clean[i]` leaves its idle level.
- `release`  out  N_CH  one-cycle pulse when `clean[i]` returns to its idle level.
- `stuck`  out  N_CH  channel has been active for ≥ `STUCK_CYCLES` cycles.
- `fault_any`  out  1  OR of `stuck`.

## Operation
- **Synchronizer:** two flops per channel, `s1` then `s2`. Both reset to `IDLE_LEVEL`.
- **Debounce:** one counter per channel, sized to hold `DEBOUNCE`, reset to 0. Each edge evaluates the following:
  - If `s2[i] == clean[i]`, the counter clears.
  - Otherwise the counter increments.
  - When the increment would reach `DEBOUNCE`, `clean[i]` takes `s2[i]` and the counter clears.
- Any sample equal to `clean[i]` restarts the count. A glitch shorter than `DEBOUNCE` samples never reaches `clean`.
- **Edge pulses:**
  - `press[i]` is registered and high for exactly the one cycle in which `clean[i]` first shows the active level.
  - `release[i]` is the same for the return to idle.
  - `press` and `release` are never both high on the same channel.
- **Stuck detector:** one counter per channel, sized to hold `STUCK_CYCLES`, saturating.
  - It counts cycles while `clean[i]` is active and clears on the cycle `clean[i]` is idle.
  - `stuck[i]` = (counter ≥ `STUCK_CYCLES`). It stays high while the channel remains active and clears the cycle after `clean[i]` returns to idle.
  - Does not alter `clean`.
- Channels are fully independent. Simultaneous transitions on several channels are each handled per the rules above in the same cycle.
- **Reset values:**
  - `clean` = `IDLE_LEVEL`.
  - `press`, `release`, `stuck` = 0.
  - `fault_any` = 0.
  - All counters = 0.
- **Reset asserted mid-debounce or while stuck:** all state returns to reset values on that edge. No `press`/`release` pulse is generated by the reset itself.

## Timing
- Raw change first sampled on edge k (into `s1`), then `s2` on edge k+1.
- `clean` changes on edge k+1+`DEBOUNCE`. With the default of 2, that is 3 edges after first sample.
- `press`/`release` are high during the cycle following that same edge, and low on the next edge.
- `stuck[i]` rises on the edge where the active count reaches `STUCK_CYCLES`, i.e. `STUCK_CYCLES` edges after the edge that made `clean[i]` active.
- `fault_any` is combinational from `stuck`: zero added latency.
- If raw returns to `clean[i]` at any point before the final qualifying sample, the count aborts and there is no output change.
- Sample counting restarts from the first differing `s2` sample after the abort.

## Test plan
Unless stated, all scenarios use parameter overrides `DEBOUNCE`=3 and `STUCK_CYCLES`=10.

1. **Reset:** hold `reset` for 2 cycles with `raw_in`=6'b000000.
   - During and after reset: `clean`=6'b111110, `press`=`release`=`stuck`=0.
   - After release, `clean` reaches 6'b000000 on the 5th edge (k+1+3), with `press`=6'b111110 for one cycle.
2. **Target press:** `raw_in[0]` 0→1 held 8 cycles, then back to 0.
   - `clean[0]`=1 at edge k+4, with a single `press[0]` pulse.
   - Return: `clean[0]`=0 four edges after first sample of 0, with a single `release[0]` pulse.
3. **Glitch reject:** `raw_in[2]` low for exactly 2 sampled cycles.
   - `clean[2]` stays 1; no `press`/`release` on any channel.
   - Repeat with a 3-cycle pulse: `clean[2]` goes 0 for ≥1 cycle with paired `press`/`release`.
4. **Simultaneous:** `raw_in[1]` and `raw_in[5]` fall on the same cycle.
   - `clean[1]` and `clean[5]` both fall on the same edge.
   - `press` = 6'b100010 for one cycle.
5. **Stuck:** `raw_in[0]` held 1 indefinitely.
   - `stuck[0]`=1 and `fault_any`=1 exactly 10 edges after `clean[0]` rises.
   - Drop raw: `stuck[0]` clears the cycle after `clean[0]` returns to 0.
6. **Reset mid-operation:** assert `reset` one cycle before a debounce completes, and again while `stuck[3]`=1.
   - All outputs return to reset values; no pulse is emitted.
   - After reset, debounce counting restarts from 0.

Source files
------------

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_conditioner
// Purpose  : Synchronizes, debounces and edge-detects the playfield sensor
//            pins; flags channels that stay active too long.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_conditioner #(
    parameter int                 N_CH         = 6,
    parameter logic [N_CH-1:0]    IDLE_LEVEL   = 6'b111110,
    parameter int                 DEBOUNCE     = 2,
    parameter int                 STUCK_CYCLES = 1100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       i_raw_in,
    output logic [N_CH-1:0]       o_clean,
    output logic [N_CH-1:0]       o_press,
    output logic [N_CH-1:0]       o_release,
    output logic [N_CH-1:0]       o_stuck,
    output logic                  o_fault_any
);

    localparam int c_DB_W = $clog2(DEBOUNCE + 1);
    localparam int c_ST_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);
    localparam logic [c_ST_W-1:0] c_ST_MAX  = c_ST_W'(STUCK_CYCLES);

    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= IDLE_LEVEL;
            r_s2 <= IDLE_LEVEL;
        end else begin
            r_s1 <= i_raw_in;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic              r_clean;
            logic              r_press;
            logic              r_release;
            logic [c_DB_W-1:0] r_db_cnt;
            logic [c_ST_W-1:0] r_st_cnt;
            logic              w_clean_nxt;
            logic [c_DB_W-1:0] w_db_nxt;

            // A sample that matches the clean level aborts any pending change.
            always_comb begin
                w_clean_nxt = r_clean;
                w_db_nxt    = '0;
                if (r_s2[i] != r_clean) begin
                    if (r_db_cnt == c_DB_LAST) begin
                        w_clean_nxt = r_s2[i];
                    end else begin
                        w_db_nxt = r_db_cnt + c_DB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_clean   <= IDLE_LEVEL[i];
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_db_cnt  <= '0;
                    r_st_cnt  <= '0;
                end else begin
                    r_clean   <= w_clean_nxt;
                    r_db_cnt  <= w_db_nxt;
                    r_press   <= (w_clean_nxt != r_clean) && (w_clean_nxt != IDLE_LEVEL[i]);
                    r_release <= (w_clean_nxt != r_clean) && (w_clean_nxt == IDLE_LEVEL[i]);
                    // Counts on the registered level, so it clears one cycle after release.
                    if (r_clean == IDLE_LEVEL[i]) begin
                        r_st_cnt <= '0;
                    end else if (r_st_cnt != c_ST_MAX) begin
                        r_st_cnt <= r_st_cnt + c_ST_W'(1);
                    end
                end
            end

            assign o_clean[i]   = r_clean;
            assign o_press[i]   = r_press;
            assign o_release[i] = r_release;
            assign o_stuck[i]   = (r_st_cnt >= c_ST_MAX);
        end
    endgenerate

    assign o_fault_any = |o_stuck;

endmodule
`default_nettype wire
